// File: rtl/test_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : test_stream_pkg
//  Description : Shared types, constants and LFSR helper for the test stream
//                source/sink blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package test_stream_pkg;

  // Sink control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS    = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'hDEADBEEF;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : test_lfsr32
//  Description : 32-bit Galois LFSR that advances only when step is high.
//                Reseeds on reset so random patterns repeat per test case.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_lfsr32
  import test_stream_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [31:0] out
);

  logic [31:0] r_lfsr;

  // Advance the generator on demand; return to the seed on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else if (step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign out = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/test_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module      : test_stream_sink
//  Description : val/rdy stream sink that checks received messages against a
//                preloaded expected table, with LFSR-driven backpressure,
//                error counting, first-error capture and timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_stream_sink
  import test_stream_pkg::*;
#(
  parameter int          NBITS     = 32,
  parameter int          DEPTH     = 16,
  parameter int          MAX_DELAY = 3,
  parameter int          TIMEOUT   = 10000,
  parameter logic [31:0] SEED      = DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [NBITS-1:0]           load_data,
  input  logic [$clog2(DEPTH):0]     num_msgs,
  input  logic                       start,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [NBITS-1:0]           in_msg,
  output logic                       done,
  output logic                       failed,
  output logic                       timed_out,
  output logic [$clog2(DEPTH):0]     err_count,
  output logic [$clog2(DEPTH)-1:0]   first_err_idx,
  output logic [31:0]                cycles
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_cw    = c_aw + 1;
  // Delay counter is kept at least one bit wide even when stalls are disabled
  localparam int c_dly_w = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [NBITS-1:0]   r_mem [DEPTH];
  logic [c_cw-1:0]    r_num;
  logic [c_aw-1:0]    r_idx;
  logic [c_cw-1:0]    r_err;
  logic [c_aw-1:0]    r_first;
  logic [31:0]        r_cycles;
  logic               r_timed_out;
  logic [c_dly_w-1:0] r_dly;

  logic [31:0]        w_lfsr;
  logic [c_dly_w-1:0] w_dly_draw;
  logic               w_step;
  logic               w_xfer;
  logic               w_last;
  logic               w_active;
  logic               w_tmo_hit;
  logic               w_set_tmo;
  logic               w_start_ok;
  logic               w_unused_lfsr;

  test_lfsr32 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (w_step),
    .out  (w_lfsr)
  );

  // The delay is taken from the pre-step LFSR value; no stalls when disabled
  generate
    if (MAX_DELAY == 0) begin : g_no_delay
      assign w_dly_draw = '0;
    end else begin : g_delay
      assign w_dly_draw = w_lfsr[c_dly_w-1:0];
    end
  endgenerate

  assign w_unused_lfsr = ^w_lfsr;

  assign w_active   = (r_state == WAIT) || (r_state == RECV);
  assign w_xfer     = (r_state == RECV) && in_val;
  assign w_last     = (c_cw'(r_idx) == (r_num - c_cw'(1)));
  assign w_tmo_hit  = w_active && (r_cycles == 32'(TIMEOUT - 1));
  // A final transfer landing on the timeout cycle counts as a clean finish
  assign w_set_tmo  = w_tmo_hit && !(w_xfer && w_last);
  assign w_start_ok = ((r_state == IDLE) || (r_state == DONE)) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, LFSR draw request and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    in_rdy       = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (start) begin
          if (num_msgs == '0) begin
            w_state_next = DONE;
          end else begin
            w_step       = 1'b1;
            w_state_next = (w_dly_draw != '0) ? WAIT : RECV;
          end
        end
      end
      WAIT: begin
        if (w_tmo_hit) begin
          w_state_next = DONE;
        end else if (r_dly == c_dly_w'(1)) begin
          w_state_next = RECV;
        end
      end
      RECV: begin
        in_rdy = 1'b1;
        if (w_xfer && w_last) begin
          w_state_next = DONE;
        end else if (w_tmo_hit) begin
          w_state_next = DONE;
        end else if (w_xfer) begin
          w_step       = 1'b1;
          w_state_next = (w_dly_draw != '0) ? WAIT : RECV;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Expected-message table: writable only while idle, never reset
  always_ff @(posedge clk) begin
    if (load_en && (r_state == IDLE)) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // Check bookkeeping: index, error tracking, cycle count, stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num       <= '0;
      r_idx       <= '0;
      r_err       <= '0;
      r_first     <= '0;
      r_cycles    <= '0;
      r_timed_out <= 1'b0;
      r_dly       <= '0;
    end else begin
      if (w_start_ok) begin
        r_num       <= num_msgs;
        r_idx       <= '0;
        r_err       <= '0;
        r_first     <= '0;
        r_cycles    <= '0;
        r_timed_out <= 1'b0;
      end
      if (w_active) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (w_xfer) begin
        if (in_msg != r_mem[r_idx]) begin
          r_err <= r_err + c_cw'(1);
          if (r_err == '0) begin
            r_first <= r_idx;
          end
        end
        r_idx <= r_idx + c_aw'(1);
      end
      if (w_set_tmo) begin
        r_timed_out <= 1'b1;
      end
      if (w_step) begin
        r_dly <= w_dly_draw;
      end else if (r_state == WAIT) begin
        r_dly <= r_dly - c_dly_w'(1);
      end
    end
  end

  assign failed        = done && ((r_err != '0) || r_timed_out);
  assign timed_out     = r_timed_out;
  assign err_count     = r_err;
  assign first_err_idx = r_first;
  assign cycles        = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_test_stream_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_stream_sink
//  Description : Self-checking bench for test_stream_sink: one instance with
//                stalls disabled and a short timeout, one with random stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_stream_sink;

  localparam int          NB   = 32;
  localparam int          DP   = 16;
  localparam int          AW   = 4;
  localparam int          CW   = 5;
  localparam int          TO0  = 20;
  localparam int          TO1  = 1000;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] SD   = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          load_en       [2];
  logic [AW-1:0] load_addr     [2];
  logic [NB-1:0] load_data     [2];
  logic [CW-1:0] num_msgs      [2];
  logic          start         [2];
  logic          in_val        [2];
  logic [NB-1:0] in_msg        [2];
  logic          in_rdy        [2];
  logic          done          [2];
  logic          failed        [2];
  logic          timed_out     [2];
  logic [CW-1:0] err_count     [2];
  logic [AW-1:0] first_err_idx [2];
  logic [31:0]   cycles        [2];

  test_stream_sink #(.NBITS(NB), .DEPTH(DP), .MAX_DELAY(0), .TIMEOUT(TO0), .SEED(SD)) u_sink0 (
    .clk(clk), .rst(rst), .load_en(load_en[0]), .load_addr(load_addr[0]), .load_data(load_data[0]),
    .num_msgs(num_msgs[0]), .start(start[0]), .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_msg(in_msg[0]),
    .done(done[0]), .failed(failed[0]), .timed_out(timed_out[0]), .err_count(err_count[0]),
    .first_err_idx(first_err_idx[0]), .cycles(cycles[0]));

  test_stream_sink #(.NBITS(NB), .DEPTH(DP), .MAX_DELAY(3), .TIMEOUT(TO1), .SEED(SD)) u_sink1 (
    .clk(clk), .rst(rst), .load_en(load_en[1]), .load_addr(load_addr[1]), .load_data(load_data[1]),
    .num_msgs(num_msgs[1]), .start(start[1]), .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_msg(in_msg[1]),
    .done(done[1]), .failed(failed[1]), .timed_out(timed_out[1]), .err_count(err_count[1]),
    .first_err_idx(first_err_idx[1]), .cycles(cycles[1]));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: expected table contents and backpressure generator
  logic [31:0]   lfsr_m [2];
  logic [NB-1:0] tab_m  [2][DP];

  typedef struct {
    int          k;
    int          n;
    int          pval;
    logic [15:0] bad;
    logic        junk;
    int          e_err;
    int          e_first;
    int          e_cyc;
  } vec_t;

  vec_t vecs [8];
  bit   trace_a [10];
  bit   trace_b [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int timeout_of(input int k);
    return (k == 0) ? TO0 : TO1;
  endfunction

  // Each accept window is preceded by a stall of 0..MAX_DELAY cycles drawn from the LFSR
  function automatic int draw(input int k);
    int d;
    d = (k == 0) ? 0 : int'(lfsr_m[k] % 32'd4);
    lfsr_m[k] = (lfsr_m[k] >> 1) ^ (lfsr_m[k][0] ? TAPS : 32'h0);
    return d;
  endfunction

  task automatic rst_all();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_en[k] = 1'b0; load_addr[k] = '0; load_data[k] = '0; num_msgs[k] = '0;
      start[k] = 1'b0; in_val[k] = 1'b0; in_msg[k] = '0;
      lfsr_m[k] = SD;
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input int k);
    check($sformatf("rst_in_rdy%0d", k), 32'(in_rdy[k]), 0);
    check($sformatf("rst_done%0d", k), 32'(done[k]), 0);
    check($sformatf("rst_failed%0d", k), 32'(failed[k]), 0);
    check($sformatf("rst_timed_out%0d", k), 32'(timed_out[k]), 0);
    check($sformatf("rst_err_count%0d", k), 32'(err_count[k]), 0);
    check($sformatf("rst_first_err%0d", k), 32'(first_err_idx[k]), 0);
    check($sformatf("rst_cycles%0d", k), cycles[k], 0);
  endtask

  task automatic load_tab(input int k);
    for (int j = 0; j < DP; j++) begin
      tab_m[k][j]  = 32'h11 * 32'(j + 1);
      load_en[k]   = 1'b1;
      load_addr[k] = AW'(j);
      load_data[k] = tab_m[k][j];
      tick();
    end
    load_en[k] = 1'b0;
  endtask

  task automatic do_start(input int k, input int n, output int stall);
    num_msgs[k] = CW'(n);
    start[k]    = 1'b1;
    tick();
    start[k]    = 1'b0;
    stall       = (n > 0) ? draw(k) : 0;
  endtask

  task automatic run_case(input int c, input vec_t v);
    int k, stall, i, ecyc, eerr, efirst;
    bit tmo, exp_rdy, vv;
    logic [NB-1:0] m;
    k = v.k; i = 0; ecyc = 0; eerr = 0; efirst = 0; tmo = 1'b0;
    do_start(k, v.n, stall);
    while (i < v.n && !tmo) begin
      exp_rdy = (stall == 0);
      check($sformatf("c%0d_in_rdy_cyc%0d", c, ecyc), 32'(in_rdy[k]), 32'(exp_rdy));
      vv = ($urandom_range(99) < v.pval);
      m  = v.bad[i] ? 32'h0000_0BAD : tab_m[k][i];
      in_val[k] = vv;
      in_msg[k] = vv ? m : $urandom;
      if (v.junk) begin
        load_en[k] = 1'b1; load_addr[k] = AW'($urandom); load_data[k] = $urandom;
      end
      ecyc++;
      if (vv && exp_rdy) begin
        if (m != tab_m[k][i]) begin
          if (eerr == 0) efirst = i;
          eerr++;
        end
        i++;
        if (i < v.n) stall = draw(k);
      end else if (stall > 0) begin
        stall--;
      end
      if (i < v.n && ecyc == timeout_of(k)) tmo = 1'b1;
      tick();
    end
    in_val[k]  = 1'b0;
    load_en[k] = 1'b0;
    if (v.junk) begin
      load_en[k] = 1'b1; load_addr[k] = '0; load_data[k] = 32'hFFFF_FFFF;
      tick();
      load_en[k] = 1'b0;
    end
    check($sformatf("c%0d_done", c), 32'(done[k]), 1);
    check($sformatf("c%0d_in_rdy_done", c), 32'(in_rdy[k]), 0);
    check($sformatf("c%0d_err_model", c), 32'(err_count[k]), 32'(eerr));
    check($sformatf("c%0d_err_const", c), 32'(err_count[k]), 32'(v.e_err));
    check($sformatf("c%0d_first_model", c), 32'(first_err_idx[k]), 32'(efirst));
    check($sformatf("c%0d_first_const", c), 32'(first_err_idx[k]), 32'(v.e_first));
    check($sformatf("c%0d_timed_out", c), 32'(timed_out[k]), 32'(tmo));
    check($sformatf("c%0d_failed", c), 32'(failed[k]), 32'((eerr != 0) || tmo));
    check($sformatf("c%0d_cycles", c), cycles[k], 32'(ecyc));
    if (v.e_cyc >= 0) check($sformatf("c%0d_cycles_const", c), cycles[k], 32'(v.e_cyc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, got, budget;
    //           k  n   pval bad       junk  err first cyc
    vecs[0] = '{0,  3, 100, 16'h0000, 1'b0,  0,  0,    3};
    vecs[1] = '{1,  4, 100, 16'h0004, 1'b0,  1,  2,   -1};
    vecs[2] = '{1,  5, 100, 16'h000A, 1'b0,  2,  1,   -1};
    vecs[3] = '{0,  0, 100, 16'h0000, 1'b0,  0,  0,    0};
    vecs[4] = '{1, 16,  60, 16'h0000, 1'b1,  0,  0,   -1};
    vecs[5] = '{1,  8,  50, 16'h0081, 1'b0,  2,  0,   -1};
    vecs[6] = '{0, 16, 100, 16'h8000, 1'b1,  1, 15,   16};
    vecs[7] = '{1, 16,  70, 16'hFFFF, 1'b0, 16,  0,   -1};

    rst_all();
    check_reset(0);
    check_reset(1);
    load_tab(0);
    load_tab(1);

    for (int c = 0; c < 8; c++) run_case(c, vecs[c]);

    // Timeout with no traffic: forced finish after TIMEOUT active cycles
    do_start(0, 5, st);
    repeat (19) tick();
    check("tmo_not_yet_done", 32'(done[0]), 0);
    tick();
    check("tmo_done", 32'(done[0]), 1);
    check("tmo_timed_out", 32'(timed_out[0]), 1);
    check("tmo_cycles", cycles[0], 20);
    check("tmo_failed", 32'(failed[0]), 1);
    check("tmo_err_count", 32'(err_count[0]), 0);

    // Final transfer exactly on the timeout cycle wins over the timeout
    do_start(0, 3, st);
    repeat (17) tick();
    for (int j = 0; j < 3; j++) begin
      in_val[0] = 1'b1;
      in_msg[0] = tab_m[0][j];
      tick();
    end
    in_val[0] = 1'b0;
    check("tmo_race_done", 32'(done[0]), 1);
    check("tmo_race_timed_out", 32'(timed_out[0]), 0);
    check("tmo_race_failed", 32'(failed[0]), 0);
    check("tmo_race_cycles", cycles[0], 20);
    check("tmo_race_err_count", 32'(err_count[0]), 0);

    // Abort mid-check with reset, then rerun: stall pattern must repeat
    rst_all();
    load_tab(1);
    do_start(1, 16, st);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      trace_a[c]   = in_rdy[1];
      in_val[1]    = 1'b1;
      in_msg[1]    = tab_m[1][got % DP];
      load_en[1]   = in_rdy[1];
      load_addr[1] = AW'(got + 1);
      load_data[1] = 32'hDEAD_0000;
      if (in_rdy[1]) got++;
      tick();
    end
    in_val[1]  = 1'b0;
    load_en[1] = 1'b0;
    budget = 0;
    while (!in_rdy[1] && budget < 8) begin
      tick();
      budget++;
    end
    check("mid_in_rdy_before_rst", 32'(in_rdy[1]), 1);
    rst_all();
    check_reset(1);
    load_tab(1);
    do_start(1, 16, st);
    got = 0;
    budget = 0;
    while (!done[1] && budget < 200) begin
      if (budget < 10) trace_b[budget] = in_rdy[1];
      in_val[1]    = 1'b1;
      in_msg[1]    = tab_m[1][got % DP];
      load_en[1]   = in_rdy[1];
      load_addr[1] = AW'(got + 1);
      load_data[1] = 32'hDEAD_0000;
      if (in_rdy[1]) got++;
      tick();
      budget++;
    end
    in_val[1]  = 1'b0;
    load_en[1] = 1'b0;
    for (int c = 0; c < 10; c++)
      check($sformatf("repro_in_rdy_cyc%0d", c), 32'(trace_b[c]), 32'(trace_a[c]));
    check("repro_done", 32'(done[1]), 1);
    check("repro_err_count", 32'(err_count[1]), 0);
    check("repro_failed", 32'(failed[1]), 0);
    check("repro_transfers", 32'(got), 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/test_stream_sink.md
Name: test_stream_sink

Overview:
Synthesizable val/rdy stream sink that consumes a DUT output stream and checks it in hardware against a preloaded table of expected messages. It is the receiving/checking counterpart to the bench-side clock/reset and equality-check utilities. It inserts pseudo-random backpressure from a seeded LFSR, then reports done, failed, error count, first-error index and timeout. Benches instantiate one per DUT output port.

Parameters:
NBITS, 32, message width in bits
DEPTH, 16, expected-message table entries; power of 2, >= 2
MAX_DELAY, 3, max random stall cycles before each accept; must be 2^k-1 (0 = no stalls)
TIMEOUT, 10000, active cycles before forced finish
SEED, 32'hDEADBEEF, LFSR reset value; nonzero

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
load_en  in  1  write expected table (honoured only in IDLE)
load_addr  in  $clog2(DEPTH)  table write address
load_data  in  NBITS  expected message
num_msgs  in  $clog2(DEPTH)+1  messages to expect; sampled on start
start  in  1  begin checking (IDLE or DONE only)
in_val  in  1  DUT message valid
in_rdy  out  1  sink ready
in_msg  in  NBITS  DUT message
done  out  1  check finished (sticky until start/rst)
failed  out  1  done & (err_count!=0 | timed_out)
timed_out  out  1  TIMEOUT reached before all messages
err_count  out  $clog2(DEPTH)+1  mismatching messages
first_err_idx  out  $clog2(DEPTH)  index of first mismatch (0 if none)
cycles  out  32  active cycles since start

Behaviour:
- Reset values: in_rdy=0, done=0, failed=0, timed_out=0, err_count=0, first_err_idx=0, cycles=0, state=IDLE, LFSR=SEED, idx=0. Table contents are not reset.
- LFSR: 32-bit Galois, taps 32'h80200003. Steps once per delay draw only. Delay = lfsr[DW-1:0] with DW=$clog2(MAX_DELAY+1), using the pre-step value. MAX_DELAY=0 always gives delay 0.
- IDLE: in_rdy=0. load_en writes mem[load_addr]<=load_data at the clock edge. On start: latch num_msgs and clear idx, err_count, first_err_idx, cycles and timed_out. If num_msgs==0, go to DONE. Otherwise draw a delay: nonzero goes to WAIT, zero goes to RECV.
- WAIT: in_rdy=0. Decrement the delay counter; go to RECV in the cycle after the counter reads 1.
- RECV: in_rdy=1 (combinational from state). A transfer occurs in a cycle with in_val & in_rdy; messages are compared on that edge.
  - On a mismatch (in_msg != mem[idx]): err_count++. If err_count was 0, first_err_idx<=idx.
  - idx++. If idx==num_msgs-1, go to DONE; else draw the next delay (nonzero to WAIT, zero to stay in RECV).
  - in_val=0 leaves the sink in RECV with no change.
- DONE: in_rdy=0 and done=1. failed is valid in the same cycle. Holds until start (restart, same as from IDLE) or rst. load_en is ignored in DONE; restarting with new data requires rst.
- cycles increments every cycle in WAIT/RECV. When cycles reaches TIMEOUT-1 and no transfer completes the final message that cycle, go to DONE with timed_out=1. If the final transfer and the timeout coincide, the transfer wins and timed_out=0.
- load_en in WAIT/RECV/DONE is ignored. start in WAIT/RECV is ignored.
- rst mid-check aborts to IDLE with reset values; the LFSR reseeds, so stall patterns are reproducible per test case.
- Latency: first possible accept is 1 cycle after start (delay 0). done asserts 1 cycle after the final transfer edge.

Decomposition:
- Package test_stream_pkg: state enum {IDLE, WAIT, RECV, DONE}, LFSR_TAPS=32'h80200003, DEFAULT_SEED=32'hDEADBEEF.
- Sub-module test_lfsr32 (SEED parameter, clk, rst, step in, out[31:0]) shared with a future test_stream_source.
- Table: plain register array in the top module.

Test Plan:
- MAX_DELAY=0; load {0x11,0x22,0x33}, num_msgs=3. Drive matching messages with in_val held high -> in_rdy high for 3 consecutive cycles, done 1 cycle after the third transfer, err_count=0, failed=0, cycles=3.
- MAX_DELAY=3; load 4 entries and send entry 2 as 0xBAD. The bench checks no transfer occurs while in_rdy=0 -> err_count=1, first_err_idx=2, failed=1 after 4 transfers.
- Two mismatches at idx 1 and 3 -> err_count=2, first_err_idx=1 (first one kept).
- num_msgs=0 with start -> done=1 next cycle, failed=0, in_rdy never asserted.
- TIMEOUT=20; in_val held 0 -> done and timed_out assert with cycles=20, failed=1. The final transfer on the timeout cycle gives timed_out=0.
- rst asserted mid-RECV, then reload and restart -> all outputs back to reset values. The stall sequence is identical to the first run, the bench compares cycle-by-cycle in_rdy traces, and load_en during RECV leaves the table unchanged.
